// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 command constants and FSM encodings for the LCD text driver
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;

    typedef enum logic [1:0] {PWR, INIT, IDLE, REFRESH} top_state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD, WAIT} wr_phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = FUNC_SET;
            2'd1:    init_cmd = DISP_ON;
            2'd2:    init_cmd = ENTRY;
            default: init_cmd = CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// rtl/lcd_text_driver_if.sv - display code input and LCD pin bundle
interface lcd_text_driver_if;
    logic [3:0] code;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       busy;

    modport master (input code, output lcd_e, lcd_rs, lcd_rw, lcd_data, busy);
    modport slave  (output code, input lcd_e, lcd_rs, lcd_rw, lcd_data, busy);
endinterface

// File: rtl/lcd_msg_rom.sv
// rtl/lcd_msg_rom.sv - line 1 text "TRAFFIC STATE n " with digit substitution at idx 14
module lcd_msg_rom (
    input  logic [3:0] i_idx,
    input  logic [3:0] i_code,
    output logic [7:0] o_char
);
    logic w_code_ok;
    assign w_code_ok = (i_code >= 4'd1) && (i_code <= 4'd8);

    always_comb begin
        o_char = 8'h20;
        case (i_idx)
            4'd0:  o_char = 8'h54;
            4'd1:  o_char = 8'h52;
            4'd2:  o_char = 8'h41;
            4'd3:  o_char = 8'h46;
            4'd4:  o_char = 8'h46;
            4'd5:  o_char = 8'h49;
            4'd6:  o_char = 8'h43;
            4'd7:  o_char = 8'h20;
            4'd8:  o_char = 8'h53;
            4'd9:  o_char = 8'h54;
            4'd10: o_char = 8'h41;
            4'd11: o_char = 8'h54;
            4'd12: o_char = 8'h45;
            4'd13: o_char = 8'h20;
            4'd14: o_char = w_code_ok ? {4'h3, i_code} : 8'h2D;
            default: o_char = 8'h20;
        endcase
    end
endmodule

// File: rtl/lcd_text_driver.sv
// rtl/lcd_text_driver.sv - HD44780 8-bit write-only driver: power-up init, then line 1 refresh on code change
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int E_PULSE  = 4,
    parameter int CMD_WAIT = 2000,
    parameter int CLR_WAIT = 80000,
    parameter int PWR_WAIT = 750000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_text_driver_if.master  bus
);
    localparam int MAX_A = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int MAX_B = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
    localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXW + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE - 1);

    top_state_t      r_state, n_state;
    wr_phase_t       r_phase, n_phase;
    logic [CW-1:0]   r_cnt, n_cnt;
    logic [3:0]      r_idx, n_idx;
    logic            r_first, n_first;
    logic [3:0]      r_shown, n_shown;
    logic [7:0]      r_data, n_data;
    logic            r_rs, n_rs;

    logic [3:0]      w_rom_idx;
    logic [7:0]      w_char;
    logic [CW-1:0]   w_wait_last;
    logic            w_done;

    // ROM is addressed with the index of the character about to be loaded
    assign w_rom_idx   = r_first ? 4'd0 : r_idx + 4'd1;
    assign w_wait_last = (!r_rs && r_data == CLEAR) ? CLR_LAST : CMD_LAST;

    lcd_msg_rom u_rom (
        .i_idx  (w_rom_idx),
        .i_code (r_shown),
        .o_char (w_char)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PWR;
            r_phase <= SETUP;
            r_cnt   <= '0;
            r_idx   <= 4'd0;
            r_first <= 1'b0;
            r_shown <= 4'd0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
        end else begin
            r_state <= n_state;
            r_phase <= n_phase;
            r_cnt   <= n_cnt;
            r_idx   <= n_idx;
            r_first <= n_first;
            r_shown <= n_shown;
            r_data  <= n_data;
            r_rs    <= n_rs;
        end
    end

    always_comb begin
        n_state = r_state;
        n_phase = r_phase;
        n_cnt   = r_cnt;
        n_idx   = r_idx;
        n_first = r_first;
        n_shown = r_shown;
        n_data  = r_data;
        n_rs    = r_rs;
        w_done  = 1'b0;

        case (r_state)
            PWR: begin
                if (r_cnt == PWR_LAST) begin
                    n_state = INIT;
                    n_phase = SETUP;
                    n_cnt   = '0;
                    n_idx   = 4'd0;
                    n_data  = FUNC_SET;
                    n_rs    = 1'b0;
                end else begin
                    n_cnt = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (bus.code != r_shown) begin
                    n_state = REFRESH;
                    n_phase = SETUP;
                    n_cnt   = '0;
                    n_first = 1'b1;
                    n_shown = bus.code;
                    n_data  = LINE1;
                    n_rs    = 1'b0;
                end
            end
            default: begin
                case (r_phase)
                    SETUP: begin
                        n_phase = PULSE;
                        n_cnt   = '0;
                    end
                    PULSE: begin
                        if (r_cnt == E_LAST) begin
                            n_phase = HOLD;
                            n_cnt   = '0;
                        end else begin
                            n_cnt = r_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        n_phase = WAIT;
                        n_cnt   = '0;
                    end
                    default: begin
                        if (r_cnt == w_wait_last) w_done = 1'b1;
                        else                      n_cnt  = r_cnt + 1'b1;
                    end
                endcase

                if (w_done) begin
                    n_phase = SETUP;
                    n_cnt   = '0;
                    if (r_state == INIT) begin
                        if (r_idx == 4'd3) begin
                            // first refresh after init is unconditional
                            n_state = REFRESH;
                            n_first = 1'b1;
                            n_shown = bus.code;
                            n_data  = LINE1;
                            n_rs    = 1'b0;
                        end else begin
                            n_idx  = r_idx + 4'd1;
                            n_data = init_cmd(r_idx[1:0] + 2'd1);
                            n_rs   = 1'b0;
                        end
                    end else if (r_first) begin
                        n_first = 1'b0;
                        n_idx   = 4'd0;
                        n_data  = w_char;
                        n_rs    = 1'b1;
                    end else if (r_idx == 4'd15) begin
                        n_state = IDLE;
                    end else begin
                        n_idx  = r_idx + 4'd1;
                        n_data = w_char;
                        n_rs   = 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.lcd_e    = (r_state == INIT || r_state == REFRESH) && (r_phase == PULSE);
    assign bus.lcd_rs   = r_rs;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_data = r_data;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_lcd_text_driver.sv
// tb/tb_lcd_text_driver.sv - scoreboard bench for lcd_text_driver
module tb_lcd_text_driver;
    localparam int E_PULSE  = 2;
    localparam int CMD_WAIT = 4;
    localparam int CLR_WAIT = 8;
    localparam int PWR_WAIT = 10;
    localparam int REFRESH_CYC = 17 * (2 + E_PULSE + CMD_WAIT);
    localparam int INIT_CYC = PWR_WAIT + 3 * (2 + E_PULSE + CMD_WAIT)
                            + (2 + E_PULSE + CLR_WAIT) + REFRESH_CYC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_text_driver_if bus ();

    lcd_text_driver #(
        .E_PULSE  (E_PULSE),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT),
        .PWR_WAIT (PWR_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } wr_t;

    wr_t q[$];
    int total = 0;
    int bad   = 0;

    logic [7:0] line_txt [16] = '{8'h54, 8'h52, 8'h41, 8'h46, 8'h46, 8'h49, 8'h43, 8'h20,
                                  8'h53, 8'h54, 8'h41, 8'h54, 8'h45, 8'h20, 8'h00, 8'h20};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input int gap);
        wr_t it;
        it.rs = rs;
        it.data = data;
        it.gap = gap;
        q.push_back(it);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, PWR_WAIT + 1);
        push(1'b0, 8'h0C, CMD_WAIT + 2);
        push(1'b0, 8'h06, CMD_WAIT + 2);
        push(1'b0, 8'h01, CMD_WAIT + 2);
    endtask

    task automatic push_line(input logic [7:0] dig, input int g0);
        push(1'b0, 8'h80, g0);
        for (int i = 0; i < 16; i++)
            push(1'b1, (i == 14) ? dig : line_txt[i], CMD_WAIT + 2);
    endtask

    task automatic wait_busy_count(input int start, input int exp_n, input string name);
        int n;
        n = start;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
        chk(name, n, exp_n);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy) break;
        end
        chk(name, int'(q.size() == 0 && !bus.busy), 1);
    endtask

    task automatic wait_rises(input int n, input string name);
        int   cnt;
        logic prev;
        cnt  = 0;
        prev = bus.lcd_e;
        for (int k = 0; k < 3000 && cnt < n; k++) begin
            @(negedge clk);
            if (bus.lcd_e && !prev) cnt++;
            prev = bus.lcd_e;
        end
        chk(name, cnt, n);
    endtask

    task automatic run_refresh(input logic [3:0] c, input logic [7:0] dig, input string name);
        push_line(dig, -1);
        @(posedge clk);
        #1 bus.code = c;
        @(negedge clk);
        chk({name, "_still_idle"}, int'(bus.busy), 0);
        @(negedge clk);
        chk({name, "_busy_rise"}, int'(bus.busy), 1);
        chk({name, "_e_low_setup"}, int'(bus.lcd_e), 0);
        @(negedge clk);
        chk({name, "_e_rise"}, int'(bus.lcd_e), 1);
        wait_busy_count(2, REFRESH_CYC, {name, "_busy_len"});
        chk({name, "_all_writes"}, q.size(), 0);
    endtask

    // monitor: pops expected writes on each lcd_e rise and checks strobe shape
    initial begin
        logic       prev_e;
        int         hi, lo;
        logic [7:0] lat_data;
        logic       lat_rs;
        wr_t        it;
        prev_e = 1'b0; hi = 0; lo = 0; lat_data = 8'h00; lat_rs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_e = 1'b0; hi = 0; lo = 0;
            end else begin
                if (bus.lcd_e && !prev_e) begin
                    if (q.size() == 0) begin
                        chk("unexpected_write", int'(bus.lcd_data), -1);
                    end else begin
                        it = q.pop_front();
                        chk("wr_rs", int'(bus.lcd_rs), int'(it.rs));
                        chk("wr_data", int'(bus.lcd_data), int'(it.data));
                        chk("wr_rw", int'(bus.lcd_rw), 0);
                        if (it.gap >= 0) chk("wr_gap", lo, it.gap);
                    end
                    lat_data = bus.lcd_data;
                    lat_rs   = bus.lcd_rs;
                    hi = 1;
                    lo = 0;
                end else if (bus.lcd_e) begin
                    hi++;
                    chk("pulse_data_stable", int'(bus.lcd_data), int'(lat_data));
                end else begin
                    if (prev_e) begin
                        chk("pulse_width", hi, E_PULSE);
                        chk("hold_data_stable", int'(bus.lcd_data), int'(lat_data));
                        chk("hold_rs_stable", int'(bus.lcd_rs), int'(lat_rs));
                    end
                    lo++;
                end
                prev_e = bus.lcd_e;
            end
        end
    end

    initial begin
        bus.code = 4'd3;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_e", int'(bus.lcd_e), 0);
        chk("rst_rs", int'(bus.lcd_rs), 0);
        chk("rst_rw", int'(bus.lcd_rw), 0);
        chk("rst_data", int'(bus.lcd_data), 0);
        chk("rst_busy", int'(bus.busy), 1);

        @(posedge clk);
        push_init();
        push_line(8'h33, CLR_WAIT + 2);
        #1 rst = 1'b1;
        wait_busy_count(0, INIT_CYC, "init_busy_len");
        chk("init_all_writes", q.size(), 0);

        run_refresh(4'd7, 8'h37, "code7");
        run_refresh(4'd9, 8'h2D, "code9");

        // change during the 3rd character: finish with 2, then refresh again with 5
        push_line(8'h32, -1);
        push_line(8'h35, CMD_WAIT + 3);
        @(posedge clk);
        #1 bus.code = 4'd2;
        wait_rises(4, "mid_change_rises");
        @(posedge clk);
        #1 bus.code = 4'd5;
        drain("mid_change_drain");

        // 5 -> 2 starts a refresh; 2 -> 5 -> 2 inside it must not cause another
        push_line(8'h32, -1);
        @(posedge clk);
        #1 bus.code = 4'd2;
        wait_rises(5, "bounce_rises");
        @(posedge clk);
        #1 bus.code = 4'd5;
        repeat (3) @(posedge clk);
        #1 bus.code = 4'd2;
        drain("bounce_drain");
        repeat (40) @(negedge clk);
        chk("bounce_no_refresh", int'(bus.busy), 0);
        chk("bounce_queue", q.size(), 0);

        // reset in the middle of a strobe
        push(1'b0, 8'h80, -1);
        @(posedge clk);
        #1 bus.code = 4'd8;
        wait_rises(1, "abort_rise");
        #2 rst = 1'b0;
        #1;
        chk("abort_e", int'(bus.lcd_e), 0);
        chk("abort_data", int'(bus.lcd_data), 0);
        chk("abort_busy", int'(bus.busy), 1);
        chk("abort_rs", int'(bus.lcd_rs), 0);
        repeat (3) @(posedge clk);
        push_init();
        push_line(8'h34, CLR_WAIT + 2);
        bus.code = 4'd4;
        #1 rst = 1'b1;
        wait_busy_count(0, INIT_CYC, "reinit_busy_len");
        chk("reinit_all_writes", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode. It consumes the 4-bit display code produced by the traffic controller's display-state mapper (1..8 = controller phase) and shows it on line 1 as text. It sits between that mapper and the board LCD pins. It runs the power-up init sequence, then rewrites line 1 whenever the code changes.

## Interface
Parameters:
- E_PULSE, 4: cycles lcd_e is held high per write (≥1).
- CMD_WAIT, 2000: idle cycles after every write except clear.
- CLR_WAIT, 80000: idle cycles after the clear-display command.
- PWR_WAIT, 750000: idle cycles after reset before the first command.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- code  in  4  display code; 1..8 valid, anything else shown as '-'.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_rw  out  1  constant 0 (write only).
- lcd_data  out  8  LCD data bus.
- busy  out  1  high while init or a refresh is in progress.

## Operation
- Top FSM states and transitions:
  - PWR: wait PWR_WAIT cycles, then INIT.
  - INIT: 4 command writes in order: 0x38, 0x0C, 0x06, 0x01. Then REFRESH.
  - IDLE: stays here while code equals shown_code. When they differ, goes to REFRESH.
  - REFRESH: command 0x80 (DDRAM address 0), then 16 character writes at idx 0..15, then IDLE.
- At REFRESH entry, code is captured into shown_code. All 16 characters use shown_code.
  - The first REFRESH after INIT is unconditional.
- Line text is "TRAFFIC STATE n ".
  - Idx 14 is ASCII '0'+shown_code (0x31..0x38) for codes 1..8, else '-' (0x2D).
  - All other positions are fixed: T,R,A,F,F,I,C,space,S,T,A,T,E,space at idx 0..13, space at idx 15.
- Write engine sub-phases for every write:
  - SETUP: 1 cycle, lcd_rs/lcd_data driven, lcd_e=0.
  - PULSE: E_PULSE cycles, lcd_e=1.
  - HOLD: 1 cycle, lcd_e=0, data unchanged.
  - WAIT: CLR_WAIT cycles after 0x01, CMD_WAIT cycles otherwise.
- lcd_rs and lcd_data must not change during PULSE or HOLD.
- Between writes, in IDLE and in PWR, lcd_data holds its last value and lcd_e=0.
- A code change during REFRESH does not abort it. After the refresh completes, IDLE compares again and starts another REFRESH if code ≠ shown_code.
  - A code that changes and returns to its old value mid-refresh causes no second refresh.
- busy is 0 only in IDLE.

## Timing
- Reset values (async, immediate): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=1, state=PWR, shown_code=0.
- Reset asserted mid-write: lcd_e drops at once. On release, restart from PWR.
- One write = 2+E_PULSE+wait cycles.
- First SETUP occurs PWR_WAIT cycles after reset release.
- Code change to first lcd_e rise: 1 cycle to IDLE compare, plus 1 cycle SETUP. The lcd_e rise is therefore 2 cycles after code changes while in IDLE.
- busy rises on the cycle IDLE leaves. It falls the cycle after the last character's WAIT ends.
- Counters: wait counter width covers max(PWR_WAIT, CLR_WAIT, CMD_WAIT). Char index is 4 bits and wraps 15→done, never re-issued.

## Structure
- Package lcd_pkg holds:
  - command constants: FUNC_SET=0x38, DISP_ON=0x0C, ENTRY=0x06, CLEAR=0x01, LINE1=0x80;
  - top-state encodings PWR/INIT/IDLE/REFRESH;
  - write sub-phase encodings SETUP/PULSE/HOLD/WAIT.
- Sub-module lcd_msg_rom is combinational: idx[3:0] and code[3:0] in, char[7:0] out. It holds the line text and the digit substitution.
- Top holds the FSM, write engine, counters and shown_code.

## Test plan
Bench parameters: E_PULSE=2, CMD_WAIT=4, CLR_WAIT=8, PWR_WAIT=10.
- Reset release with code=3: 21 lcd_e pulses, each 2 cycles wide. Latched bytes are 0x38,0x0C,0x06,0x01,0x80,0x54,0x52,…,0x33 (idx 14),0x20. lcd_rs=0 for the first 5, 1 for the rest. busy falls after the last write.
- Gap check: clear→0x80 SETUP gap = 8 idle cycles. All other inter-write gaps = 4. First SETUP occurs 10 cycles after reset release.
- In IDLE, code 3→7: busy rises next cycle and 17 writes follow (0x80 + line). idx 14 = 0x37.
- code 9 in IDLE: idx 14 = 0x2D.
- code 2→5 during the refresh's 3rd character: the current refresh completes with 0x32, then a second refresh writes 0x35. code 2→5→2 within a refresh: no second refresh.
- Reset asserted during a PULSE: lcd_e=0, lcd_data=0x00 and busy=1 the same cycle. After release, the full init sequence repeats.
